scr1_wb_mem_slave: RTL and testbench
====================================

# scr1_wb_mem_slave

Synthesizable Wishbone classic-cycle slave memory that answers the core's `wbd_imem_*` / `wbd_dmem_*` initiator ports. It holds a word-organized RAM, executes byte-enabled writes and full-word reads, and inserts a programmable number of wait states before acknowledging. It flags an error for addresses outside the array. It is the on-chip replacement for the behavioural memory model, so the same firmware images run in FPGA and gate-level builds.

## Interface
- `SCR1_MEM_POWER_SIZE`, default 12: memory size is 2**N bytes; word depth is 2**(N-2).
- `STALL_W`, default 4: width of the wait-state configuration input.
- `wb_clk`  in  1  bus clock; all state changes on its rising edge.
- `wb_rst_n`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronous to `wb_clk`.
- `stall_cfg`  in  STALL_W  wait states inserted before ack/err. Sampled only when a request is accepted.
- `wbd_stb_i`  in  1  request strobe. Held high by the initiator until ack/err.
- `wbd_adr_i`  in  SCR1_WB_WIDTH  byte address. Bits [1:0] are ignored.
- `wbd_we_i`  in  1  1 = write, 0 = read.
- `wbd_dat_i`  in  SCR1_WB_WIDTH  write data.
- `wbd_sel_i`  in  4  byte enables; bit i selects byte lane [8i+7:8i].
- `wbd_dat_o`  out  SCR1_WB_WIDTH  read data. Valid only in the ack cycle of a read; 0 at all other times.
- `wbd_ack_o`  out  1  one-cycle successful-completion pulse.
- `wbd_err_o`  out  1  one-cycle error-completion pulse. Never asserted together with ack.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE:**
  - On an edge with `wbd_stb_i`=1, capture adr/we/dat/sel and compute `oor` = (adr >= 2**SCR1_MEM_POWER_SIZE). Upper address bits are compared in full; there is no aliasing.
  - If `stall_cfg`=0: go to RESP.
  - Otherwise: load `cnt`=`stall_cfg` and go to WAIT.
- **WAIT:**
  - Each edge with stb=1 decrements `cnt`. When `cnt`=1 at the edge, go to RESP.
  - Stb=0 at any WAIT edge aborts: go to IDLE, no ack/err, no memory change.
- **Entry to RESP** (registered outputs):
  - If `oor`: `wbd_err_o`=1, `wbd_dat_o`=0, memory unchanged.
  - Else if write: `wbd_ack_o`=1 and each byte lane whose sel bit=1 is updated. Sel=0000 still acks and modifies nothing.
  - Else (read): `wbd_ack_o`=1, `wbd_dat_o`=mem[adr[N-1:2]].
- **RESP:** lasts exactly one cycle, then IDLE unconditionally. Ack/err/dat_o return to 0.
- Stb still high in the IDLE cycle after RESP is treated as a new request. The initiator must drop stb after ack if it has nothing further.
- Memory contents are not affected by reset (undefined after power-up). Only control state is reset.

## Timing
- Reset values: state=IDLE, `cnt`=0, `wbd_ack_o`=0, `wbd_err_o`=0, `wbd_dat_o`=0.
- Latency: a request sampled at edge E produces ack/err high in the cycle after edge E+`stall_cfg`. With stall 0, ack is high the cycle after the sampling edge.
- Write data is visible to a read accepted at any later edge; there is no read-after-write hazard.
- Throughput: at most one transaction per `stall_cfg`+2 cycles, because the RESP→IDLE turnaround is mandatory.
- Changes to `stall_cfg` after acceptance have no effect on the current transaction.
- Reset asserted mid-transaction: ack/err drop immediately, the pending write is discarded, state=IDLE. Memory retains prior contents.
- Reset released with stb already high: the request is accepted at the first edge after release.

## Test plan
- **Stall 0 write/read:** write 0xDEADBEEF to 0x10 with sel=1111, drop stb; read 0x10. Ack comes 1 cycle after each accept; read dat_o=0xDEADBEEF only in the ack cycle, 0 otherwise.
- **Byte enables:** preload 0x11223344 at 0x20; write 0xAABBCCDD with sel=0101; read returns 0x11BB33DD. A write with sel=0000 is acked and the read returns 0x11BB33DD unchanged.
- **Wait states:** `stall_cfg`=3, read 0x10. Ack appears exactly 4 cycles after the accept edge. Changing `stall_cfg` to 0 during WAIT does not shorten it.
- **Out of range:** N=12, read 0x1000. `wbd_err_o`=1 for one cycle, ack=0, dat_o=0. A write to 0x1000 errs, and a subsequent read of 0x0 shows unchanged data.
- **Abort and back-to-back:** `stall_cfg`=5, write 0x55 to 0x30 and drop stb after 2 cycles; no ack, and a later read of 0x30 shows the old value. Holding stb high through an ack causes a second acked transaction exactly 2 cycles later (stall 0).
- **Reset mid-op:** assert `wb_rst_n`=0 during WAIT of a write. Ack/err/dat_o go 0 asynchronously, the target word is unchanged, and the first request after release is accepted at the next edge.

Source files
------------

// File: rtl/scr1_wb_mem_slave.sv
// scr1_wb_mem_slave
// Wishbone classic-cycle slave RAM for the imem/dmem initiator ports.
// Word-organized array with byte-enabled writes, full-word reads, a
// programmable number of wait states before completion, and an error
// completion for addresses beyond the array.
//
// Ports:
//   wb_clk     bus clock, rising edge
//   wb_rst_n   async active-low reset (control state only, not the RAM)
//   stall_cfg  wait states before ack/err, sampled at request accept
//   wbd_stb_i  request strobe, held until ack/err
//   wbd_adr_i  byte address (bits [1:0] ignored)
//   wbd_we_i   1 = write, 0 = read
//   wbd_dat_i  write data
//   wbd_sel_i  byte lane enables
//   wbd_dat_o  read data, nonzero only in a read ack cycle
//   wbd_ack_o  one-cycle success pulse
//   wbd_err_o  one-cycle error pulse (out-of-range address)
//
// state | meaning
// IDLE  | waiting for stb; captures the request
// WAIT  | counting down wait states; stb low aborts
// RESP  | one-cycle ack/err; always returns to IDLE
module scr1_wb_mem_slave #(
  parameter int SCR1_MEM_POWER_SIZE = 12,
  parameter int STALL_W             = 4,
  parameter int SCR1_WB_WIDTH       = 32
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  input  logic [STALL_W-1:0]       stall_cfg,
  input  logic                     wbd_stb_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_adr_i,
  input  logic                     wbd_we_i,
  input  logic [SCR1_WB_WIDTH-1:0] wbd_dat_i,
  input  logic [3:0]               wbd_sel_i,
  output logic [SCR1_WB_WIDTH-1:0] wbd_dat_o,
  output logic                     wbd_ack_o,
  output logic                     wbd_err_o
);

  localparam int AW    = SCR1_MEM_POWER_SIZE - 2;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                   state_q;
  logic [STALL_W-1:0]       cnt_q;
  logic [AW-1:0]            idx_q, idx_d;
  logic                     oor_q, oor_d;
  logic                     we_q, we_d;
  logic [SCR1_WB_WIDTH-1:0] wdat_q, wdat_d;
  logic [3:0]               sel_q, sel_d;
  logic                     go_resp;
  logic                     mem_we;
  logic                     unused_adr_lsb;

  logic [SCR1_WB_WIDTH-1:0] mem [DEPTH];

  // Byte offset within a word has no meaning for a word-wide RAM.
  assign unused_adr_lsb = ^wbd_adr_i[1:0];

  // In IDLE the request is taken straight from the bus so a zero-stall
  // access completes on the accept edge; later it comes from the capture.
  always_comb begin
    if (state_q == ST_IDLE) begin
      idx_d  = wbd_adr_i[SCR1_MEM_POWER_SIZE-1:2];
      oor_d  = |wbd_adr_i[SCR1_WB_WIDTH-1:SCR1_MEM_POWER_SIZE];
      we_d   = wbd_we_i;
      wdat_d = wbd_dat_i;
      sel_d  = wbd_sel_i;
    end else begin
      idx_d  = idx_q;
      oor_d  = oor_q;
      we_d   = we_q;
      wdat_d = wdat_q;
      sel_d  = sel_q;
    end
  end

  assign go_resp = wbd_stb_i &&
                   (((state_q == ST_IDLE) && (stall_cfg == '0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == STALL_W'(1))));

  // Gated by reset so a request held high during reset never lands.
  assign mem_we = wb_rst_n && go_resp && !oor_d && we_d;

  always_ff @(posedge wb_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_d[b]) mem[idx_d][8*b +: 8] <= wdat_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      oor_q     <= 1'b0;
      we_q      <= 1'b0;
      wdat_q    <= '0;
      sel_q     <= '0;
      wbd_ack_o <= 1'b0;
      wbd_err_o <= 1'b0;
      wbd_dat_o <= '0;
    end else begin
      wbd_ack_o <= 1'b0;
      wbd_err_o <= 1'b0;
      wbd_dat_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (wbd_stb_i) begin
            idx_q  <= idx_d;
            oor_q  <= oor_d;
            we_q   <= we_d;
            wdat_q <= wdat_d;
            sel_q  <= sel_d;
            if (stall_cfg == '0) begin
              state_q <= ST_RESP;
            end else begin
              cnt_q   <= stall_cfg;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!wbd_stb_i) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - STALL_W'(1);
            if (cnt_q == STALL_W'(1)) state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      if (go_resp) begin
        if (oor_d) begin
          wbd_err_o <= 1'b1;
        end else begin
          wbd_ack_o <= 1'b1;
          if (!we_d) wbd_dat_o <= mem[idx_d];
        end
      end
    end
  end

endmodule

// File: tb/tb_scr1_wb_mem_slave.sv
module tb_scr1_wb_mem_slave;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [3:0]  stall_cfg;
  logic        wbd_stb_i;
  logic [31:0] wbd_adr_i;
  logic        wbd_we_i;
  logic [31:0] wbd_dat_i;
  logic [3:0]  wbd_sel_i;
  logic [31:0] wbd_dat_o;
  logic        wbd_ack_o;
  logic        wbd_err_o;

  scr1_wb_mem_slave #(.SCR1_MEM_POWER_SIZE(12), .STALL_W(4), .SCR1_WB_WIDTH(32)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .stall_cfg(stall_cfg),
    .wbd_stb_i(wbd_stb_i),
    .wbd_adr_i(wbd_adr_i),
    .wbd_we_i (wbd_we_i),
    .wbd_dat_i(wbd_dat_i),
    .wbd_sel_i(wbd_sel_i),
    .wbd_dat_o(wbd_dat_o),
    .wbd_ack_o(wbd_ack_o),
    .wbd_err_o(wbd_err_o)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        err;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [0:1023];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Builds the expected response and updates the reference memory.
  function automatic exp_t predict(input logic [31:0] adr, input logic we,
                                   input logic [31:0] dat, input logic [3:0] sel, input int stall);
    exp_t e;
    e.err = (adr[31:12] != 20'd0);
    e.dat = 32'd0;
    e.lat = stall + 1;
    if (!e.err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model[adr[11:2]][8*b +: 8] = dat[8*b +: 8];
      end else begin
        e.dat = model[adr[11:2]];
      end
    end
    return e;
  endfunction

  // Starts and ends at a point 1 time unit after a rising edge.
  task automatic txn(input string tag, input logic [31:0] adr, input logic we,
                     input logic [31:0] dat, input logic [3:0] sel, input int stall, input bit chg);
    exp_t e;
    int   n;
    bit   got;
    sb.push_back(predict(adr, we, dat, sel, stall));
    stall_cfg = 4'(stall);
    wbd_adr_i = adr;
    wbd_we_i  = we;
    wbd_dat_i = dat;
    wbd_sel_i = sel;
    wbd_stb_i = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      @(posedge wb_clk); #1;
      n++;
      if (chg && n == 1) stall_cfg = 4'd0;
      if (wbd_ack_o || wbd_err_o) got = 1'b1;
      else check({tag, "_dat_wait"}, wbd_dat_o, 32'd0);
    end
    wbd_stb_i = 1'b0;
    e = sb.pop_front();
    check({tag, "_lat"}, 32'(n), 32'(e.lat));
    check({tag, "_ack"}, 32'(wbd_ack_o), 32'(!e.err));
    check({tag, "_err"}, 32'(wbd_err_o), 32'(e.err));
    check({tag, "_dat"}, wbd_dat_o, e.dat);
    @(posedge wb_clk); #1;
    check({tag, "_post"}, {wbd_dat_o[29:0], wbd_ack_o, wbd_err_o}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   acks, first, second, n;
    bit   seen;

    wb_rst_n  = 1'b0;
    stall_cfg = 4'd0;
    wbd_stb_i = 1'b0;
    wbd_adr_i = 32'd0;
    wbd_we_i  = 1'b0;
    wbd_dat_i = 32'd0;
    wbd_sel_i = 4'h0;
    repeat (3) @(posedge wb_clk);
    #1;
    check("rst_ack", 32'(wbd_ack_o), 32'd0);
    check("rst_err", 32'(wbd_err_o), 32'd0);
    check("rst_dat", wbd_dat_o, 32'd0);
    wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;

    // Zero-stall write then read
    txn("s0_wr", 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    txn("s0_rd", 32'h10, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    txn("w0_wr", 32'h0, 1'b1, 32'hCAFEF00D, 4'hF, 0, 1'b0);

    // Byte lanes: read must yield 0x11BB33DD both times
    txn("be_pre", 32'h20, 1'b1, 32'h11223344, 4'hF, 0, 1'b0);
    txn("be_wr", 32'h20, 1'b1, 32'hAABBCCDD, 4'h5, 0, 1'b0);
    txn("be_rd", 32'h20, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    txn("be_sel0", 32'h20, 1'b1, 32'hFFFFFFFF, 4'h0, 1, 1'b0);
    txn("be_rd2", 32'h22, 1'b0, 32'h0, 4'hF, 0, 1'b0);

    // Wait states, and stall_cfg changed mid-WAIT
    txn("ws3_rd", 32'h10, 1'b0, 32'h0, 4'hF, 3, 1'b0);
    txn("ws3_chg", 32'h10, 1'b0, 32'h0, 4'hF, 3, 1'b1);

    // Out of range: no aliasing onto word 0
    txn("oor_rd", 32'h1000, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    txn("oor_wr", 32'h1000, 1'b1, 32'h12121212, 4'hF, 2, 1'b0);
    txn("oor_chk", 32'h0, 1'b0, 32'h0, 4'hF, 0, 1'b0);
    txn("oor_hi", 32'h80000010, 1'b0, 32'h0, 4'hF, 1, 1'b0);

    // Abort during WAIT
    txn("ab_pre", 32'h30, 1'b1, 32'h0BADC0DE, 4'hF, 0, 1'b0);
    stall_cfg = 4'd5;
    wbd_adr_i = 32'h30;
    wbd_we_i  = 1'b1;
    wbd_dat_i = 32'h55;
    wbd_sel_i = 4'hF;
    wbd_stb_i = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;
    wbd_stb_i = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge wb_clk); #1;
      if (wbd_ack_o || wbd_err_o) seen = 1'b1;
    end
    check("ab_noresp", 32'(seen), 32'd0);
    txn("ab_rd", 32'h30, 1'b0, 32'h0, 4'hF, 0, 1'b0);

    // Back-to-back: stb held through ack gives a second ack 2 cycles later
    sb.push_back(predict(32'h10, 1'b0, 32'h0, 4'hF, 0));
    sb.push_back(predict(32'h10, 1'b0, 32'h0, 4'hF, 0));
    stall_cfg = 4'd0;
    wbd_adr_i = 32'h10;
    wbd_we_i  = 1'b0;
    wbd_stb_i = 1'b1;
    acks = 0; first = 0; second = 0; n = 0;
    while (acks < 2 && n < 12) begin
      @(posedge wb_clk); #1;
      n++;
      if (wbd_ack_o) begin
        acks++;
        e = sb.pop_front();
        check("b2b_dat", wbd_dat_o, e.dat);
        if (acks == 1) first = n;
        else begin
          second = n;
          wbd_stb_i = 1'b0;
        end
      end
    end
    wbd_stb_i = 1'b0;
    check("b2b_first", 32'(first), 32'd1);
    check("b2b_gap", 32'(second - first), 32'd2);
    @(posedge wb_clk); #1;
    check("b2b_post", 32'(wbd_ack_o), 32'd0);

    // Reset in the ack cycle drops outputs immediately
    sb.push_back(predict(32'h10, 1'b0, 32'h0, 4'hF, 0));
    wbd_stb_i = 1'b1;
    @(posedge wb_clk); #1;
    e = sb.pop_front();
    check("rr_ack", 32'(wbd_ack_o), 32'd1);
    check("rr_dat", wbd_dat_o, e.dat);
    wbd_stb_i = 1'b0;
    wb_rst_n  = 1'b0;
    #1;
    check("rr_async", {wbd_dat_o[29:0], wbd_ack_o, wbd_err_o}, 32'd0);
    #2;
    wb_rst_n = 1'b1;
    @(posedge wb_clk); #1;

    // Reset during WAIT of a write discards the write
    stall_cfg = 4'd4;
    wbd_adr_i = 32'h10;
    wbd_we_i  = 1'b1;
    wbd_dat_i = 32'h12345678;
    wbd_sel_i = 4'hF;
    wbd_stb_i = 1'b1;
    repeat (2) @(posedge wb_clk);
    #1;
    wb_rst_n = 1'b0;
    #1;
    check("rw_async", {wbd_dat_o[29:0], wbd_ack_o, wbd_err_o}, 32'd0);
    wbd_we_i  = 1'b0;
    stall_cfg = 4'd0;
    repeat (2) @(posedge wb_clk);
    #3;
    wb_rst_n = 1'b1;
    txn("rw_rd", 32'h10, 1'b0, 32'h0, 4'hF, 0, 1'b0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
